// File: rtl/automat_seq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | automat_seq_ctrl: feeds a programmed (x,y) word into the Mealy        |
// | automaton one symbol per clock and captures its t1..t3 outputs.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module automat_seq_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         res,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [4:0]   len_i,
    input  logic [W-1:0] xseq_i,
    input  logic [W-1:0] yseq_i,
    output logic         a_res_o,
    output logic         a_x_o,
    output logic         a_y_o,
    input  logic         a_t1_i,
    input  logic         a_t2_i,
    input  logic         a_t3_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         aborted_o,
    output logic [4:0]   steps_o,
    output logic [W-1:0] tr1_o,
    output logic [W-1:0] tr2_o,
    output logic [W-1:0] tr3_o,
    output logic [4:0]   cnt1_o,
    output logic [4:0]   cnt2_o,
    output logic [4:0]   cnt3_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0]   C_WMAX  = 5'(W);
    localparam logic [W-1:0] C_SEL0  = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q;
    logic [W-1:0] xsh_q;
    logic [W-1:0] ysh_q;
    logic [W-1:0] sel_q;
    logic [4:0]   n_q;
    logic [4:0]   steps_q;
    logic [W-1:0] tr1_q;
    logic [W-1:0] tr2_q;
    logic [W-1:0] tr3_q;
    logic [4:0]   cnt1_q;
    logic [4:0]   cnt2_q;
    logic [4:0]   cnt3_q;
    logic         a_res_q;
    logic         busy_q;
    logic         done_q;
    logic         aborted_q;

    logic [4:0]   w_len;
    logic         w_run;
    logic         w_last;

    assign w_len  = (len_i > C_WMAX) ? C_WMAX : len_i;
    assign w_run  = (state_q == RUN);
    assign w_last = (steps_q == (n_q - 5'd1));

    // Operands are shifted out LSB-first, so bit 0 is always the current step.
    assign a_x_o  = w_run & xsh_q[0];
    assign a_y_o  = w_run & ysh_q[0];

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            xsh_q     <= '0;
            ysh_q     <= '0;
            sel_q     <= '0;
            n_q       <= '0;
            steps_q   <= '0;
            tr1_q     <= '0;
            tr2_q     <= '0;
            tr3_q     <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            cnt3_q    <= '0;
            a_res_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        xsh_q     <= xseq_i;
                        ysh_q     <= yseq_i;
                        sel_q     <= C_SEL0;
                        n_q       <= w_len;
                        steps_q   <= '0;
                        tr1_q     <= '0;
                        tr2_q     <= '0;
                        tr3_q     <= '0;
                        cnt1_q    <= '0;
                        cnt2_q    <= '0;
                        cnt3_q    <= '0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (w_len != 5'd0) begin
                            state_q <= RUN;
                            a_res_q <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        // The step presented in the abort cycle is discarded.
                        aborted_q <= 1'b1;
                        a_res_q   <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tr1_q   <= tr1_q | ({W{a_t1_i}} & sel_q);
                        tr2_q   <= tr2_q | ({W{a_t2_i}} & sel_q);
                        tr3_q   <= tr3_q | ({W{a_t3_i}} & sel_q);
                        cnt1_q  <= cnt1_q + 5'(a_t1_i);
                        cnt2_q  <= cnt2_q + 5'(a_t2_i);
                        cnt3_q  <= cnt3_q + 5'(a_t3_i);
                        steps_q <= steps_q + 5'd1;
                        xsh_q   <= xsh_q >> 1;
                        ysh_q   <= ysh_q >> 1;
                        sel_q   <= sel_q << 1;
                        if (w_last) begin
                            a_res_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    a_res_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_res_o   = a_res_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign aborted_o = aborted_q;
    assign steps_o   = steps_q;
    assign tr1_o     = tr1_q;
    assign tr2_o     = tr2_q;
    assign tr3_o     = tr3_q;
    assign cnt1_o    = cnt1_q;
    assign cnt2_o    = cnt2_q;
    assign cnt3_o    = cnt3_q;

endmodule
`default_nettype wire

// File: tb/tb_automat_seq_ctrl.sv
`default_nettype none
// Bench for automat_seq_ctrl: a 5-state Mealy automaton model drives a_t*,
// and a scoreboard holds the expected results of each accepted run.
module tb_automat_seq_ctrl;
    localparam int W = 16;

    typedef struct packed {
        logic [15:0] tr1;
        logic [15:0] tr2;
        logic [15:0] tr3;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic [4:0]  c3;
        logic [4:0]  steps;
        logic        ab;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  len = '0;
    logic [15:0] xseq = '0;
    logic [15:0] yseq = '0;
    logic        a_res, a_x, a_y, a_t1, a_t2, a_t3;
    logic        busy, done, aborted;
    logic [4:0]  steps, cnt1, cnt2, cnt3;
    logic [15:0] tr1, tr2, tr3;

    int   tests_run = 0;
    int   tests_fail = 0;
    exp_t sb_q[$];

    automat_seq_ctrl #(.W(W)) dut (
        .clk(clk), .res(res), .start_i(start), .abort_i(abort), .len_i(len),
        .xseq_i(xseq), .yseq_i(yseq), .a_res_o(a_res), .a_x_o(a_x), .a_y_o(a_y),
        .a_t1_i(a_t1), .a_t2_i(a_t2), .a_t3_i(a_t3), .busy_o(busy), .done_o(done),
        .aborted_o(aborted), .steps_o(steps), .tr1_o(tr1), .tr2_o(tr2), .tr3_o(tr3),
        .cnt1_o(cnt1), .cnt2_o(cnt2), .cnt3_o(cnt3)
    );

    // Automaton transition/output table: returns {next_state, t1, t2, t3}.
    function automatic logic [5:0] aut_fn(input logic [2:0] s, input logic x, input logic y);
        case ({s, x, y})
            5'b000_00: return {3'd4, 3'b011};
            5'b000_10: return {3'd1, 3'b100};
            5'b000_01: return {3'd2, 3'b010};
            5'b000_11: return {3'd3, 3'b001};
            5'b001_00: return {3'd0, 3'b000};
            5'b001_10: return {3'd2, 3'b110};
            5'b001_01: return {3'd3, 3'b101};
            5'b001_11: return {3'd4, 3'b011};
            5'b010_00: return {3'd1, 3'b001};
            5'b010_10: return {3'd3, 3'b110};
            5'b010_01: return {3'd4, 3'b100};
            5'b010_11: return {3'd0, 3'b010};
            5'b011_00: return {3'd2, 3'b010};
            5'b011_10: return {3'd4, 3'b001};
            5'b011_01: return {3'd0, 3'b111};
            5'b011_11: return {3'd1, 3'b100};
            5'b100_00: return {3'd3, 3'b101};
            5'b100_10: return {3'd0, 3'b001};
            5'b100_01: return {3'd1, 3'b100};
            5'b100_11: return {3'd2, 3'b110};
            default:   return 6'd0;
        endcase
    endfunction

    logic [2:0] aut_q = 3'd0;
    logic [5:0] aut_w;
    assign aut_w = aut_fn(aut_q, a_x, a_y);
    assign a_t1  = aut_w[2];
    assign a_t2  = aut_w[1];
    assign a_t3  = aut_w[0];
    always @(posedge clk) aut_q <= a_res ? 3'd0 : aut_w[5:3];

    function automatic exp_t model(input logic [4:0] l, input logic [15:0] xs,
                                   input logic [15:0] ys, input int abort_at);
        exp_t e;
        int n;
        logic [2:0] s;
        logic [5:0] r;
        e = '0;
        n = (l > 5'd16) ? 16 : int'(l);
        if (abort_at > 0 && abort_at <= n) begin
            n = abort_at - 1;
            e.ab = 1'b1;
        end
        s = 3'd0;
        for (int k = 0; k < n; k++) begin
            r = aut_fn(s, xs[k], ys[k]);
            e.tr1[k] = r[2];
            e.tr2[k] = r[1];
            e.tr3[k] = r[0];
            e.c1 = e.c1 + 5'(r[2]);
            e.c2 = e.c2 + 5'(r[1]);
            e.c3 = e.c3 + 5'(r[0]);
            s = r[5:3];
        end
        e.steps = 5'(n);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_fail++;
                $display("FAIL sb_unexpected_done: got done=1 required no pending run");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({tr1, tr2, tr3} !== {e.tr1, e.tr2, e.tr3}) begin
                    tests_fail++;
                    $display("FAIL sb_traces: got %h/%h/%h required %h/%h/%h",
                             tr1, tr2, tr3, e.tr1, e.tr2, e.tr3);
                end
                tests_run++;
                if ({cnt1, cnt2, cnt3} !== {e.c1, e.c2, e.c3}) begin
                    tests_fail++;
                    $display("FAIL sb_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                             cnt1, cnt2, cnt3, e.c1, e.c2, e.c3);
                end
                tests_run++;
                if ({steps, aborted} !== {e.steps, e.ab}) begin
                    tests_fail++;
                    $display("FAIL sb_steps_aborted: got %0d/%0b required %0d/%0b",
                             steps, aborted, e.steps, e.ab);
                end
            end
        end
    end

    // Drives one run and returns at the negedge of the cycle where done is seen.
    task automatic launch(input logic [4:0] l, input logic [15:0] xs, input logic [15:0] ys,
                          input int abort_at, input int restart_at,
                          output int lat, output bit ares_bad);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        xseq  = xs;
        yseq  = ys;
        sb_q.push_back(model(l, xs, ys, abort_at));
        lat = 0;
        ares_bad = 1'b0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                start = 1'b0;
                abort = 1'b0;
                break;
            end
            if (a_res !== 1'b0) ares_bad = 1'b1;
            start = (lat == restart_at);
            if (start) begin
                len  = 5'd3;
                xseq = ~xs;
            end
            abort = (lat == abort_at);
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        start = 1'b1;
        len = 5'd7;
        xseq = 16'hFFFF;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({a_res, a_x, a_y, busy, done, aborted} !== 6'b100000) begin
            tests_fail++;
            $display("FAIL reset_ctrl: got %b required 100000", {a_res, a_x, a_y, busy, done, aborted});
        end
        tests_run++;
        if ({steps, cnt1, cnt2, cnt3, tr1, tr2, tr3} !== '0) begin
            tests_fail++;
            $display("FAIL reset_results: got %h required 0", {steps, cnt1, cnt2, cnt3, tr1, tr2, tr3});
        end
        start = 1'b0;
        res = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plan_vectors();
        int lat;
        bit bad;
        launch(5'd4, 16'h000F, 16'h0000, 0, 0, lat, bad);
        tests_run++;
        if (lat !== 5) begin tests_fail++; $display("FAIL v1_latency: got %0d required 5", lat); end
        tests_run++;
        if ({tr1, tr2, tr3} !== {16'h7, 16'h6, 16'h8}) begin
            tests_fail++;
            $display("FAIL v1_traces: got %h/%h/%h required 7/6/8", tr1, tr2, tr3);
        end
        tests_run++;
        if ({cnt1, cnt2, cnt3, steps} !== {5'd3, 5'd2, 5'd1, 5'd4}) begin
            tests_fail++;
            $display("FAIL v1_counts: got %0d/%0d/%0d steps %0d required 3/2/1 steps 4", cnt1, cnt2, cnt3, steps);
        end
        tests_run++;
        if (bad) begin tests_fail++; $display("FAIL v1_ares_in_run: got 1 required 0"); end
        tests_run++;
        if ({a_res, busy} !== 2'b11) begin
            tests_fail++;
            $display("FAIL v1_done_state: got a_res/busy %b required 11", {a_res, busy});
        end

        launch(5'd2, 16'h0002, 16'h0000, 0, 0, lat, bad);
        tests_run++;
        if ({tr1, tr2, tr3, cnt1, cnt2, cnt3} !== {16'h0, 16'h1, 16'h3, 5'd0, 5'd1, 5'd2}) begin
            tests_fail++;
            $display("FAIL v2_results: got %h/%h/%h %0d/%0d/%0d required 0/1/3 0/1/2",
                     tr1, tr2, tr3, cnt1, cnt2, cnt3);
        end

        launch(5'd5, 16'h000F, 16'h0010, 0, 0, lat, bad);
        tests_run++;
        if ({tr1, tr2, tr3, cnt1} !== {16'h17, 16'h06, 16'h08, 5'd4}) begin
            tests_fail++;
            $display("FAIL v3_results: got %h/%h/%h cnt1 %0d required 17/06/08 cnt1 4", tr1, tr2, tr3, cnt1);
        end
        tests_run++;
        if (lat !== 6) begin tests_fail++; $display("FAIL v3_latency: got %0d required 6", lat); end
    endtask

    task automatic test_abort();
        int lat;
        bit bad;
        launch(5'd16, 16'hFFFF, 16'h0000, 3, 0, lat, bad);
        tests_run++;
        if ({steps, aborted, tr1} !== {5'd2, 1'b1, 16'h3}) begin
            tests_fail++;
            $display("FAIL abort_results: got steps %0d ab %b tr1 %h required 2 1 0003", steps, aborted, tr1);
        end
        tests_run++;
        if (a_res !== 1'b1) begin tests_fail++; $display("FAIL abort_ares_done: got %b required 1", a_res); end
        tests_run++;
        if (lat !== 4) begin tests_fail++; $display("FAIL abort_latency: got %0d required 4", lat); end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({steps, aborted, busy} !== {5'd2, 1'b1, 1'b0}) begin
            tests_fail++;
            $display("FAIL abort_hold: got steps %0d ab %b busy %b required 2 1 0", steps, aborted, busy);
        end
    endtask

    task automatic test_empty();
        int lat;
        bit bad;
        abort = 1'b1;
        launch(5'd0, 16'hABCD, 16'h1234, 0, 0, lat, bad);
        tests_run++;
        if (lat !== 1) begin tests_fail++; $display("FAIL empty_latency: got %0d required 1", lat); end
        tests_run++;
        if ({busy, aborted, steps, tr1, cnt1} !== {1'b1, 1'b0, 5'd0, 16'h0, 5'd0}) begin
            tests_fail++;
            $display("FAIL empty_results: got busy %b ab %b steps %0d tr1 %h cnt1 %0d required 1 0 0 0 0",
                     busy, aborted, steps, tr1, cnt1);
        end
    endtask

    task automatic test_clamp();
        int lat;
        bit bad;
        launch(5'd20, 16'($urandom), 16'($urandom), 0, 0, lat, bad);
        tests_run++;
        if (lat !== 17 || steps !== 5'd16) begin
            tests_fail++;
            $display("FAIL clamp: got lat %0d steps %0d required 17 16", lat, steps);
        end
    endtask

    task automatic test_start_busy();
        int lat;
        bit bad;
        launch(5'd6, 16'($urandom), 16'($urandom), 0, 2, lat, bad);
        tests_run++;
        if (lat !== 7 || steps !== 5'd6) begin
            tests_fail++;
            $display("FAIL start_busy: got lat %0d steps %0d required 7 6", lat, steps);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        int ab;
        int exp_lat;
        bit bad;
        for (int i = 0; i < 8; i++) begin
            n  = int'($urandom_range(16, 1));
            ab = (i % 3 == 2) ? int'($urandom_range(n, 1)) : 0;
            exp_lat = (ab > 0) ? ab + 1 : n + 1;
            launch(5'(n), 16'($urandom), 16'($urandom), ab, 0, lat, bad);
            tests_run++;
            if (lat !== exp_lat || bad) begin
                tests_fail++;
                $display("FAIL b2b_run%0d: got lat %0d ares_bad %b required lat %0d ares_bad 0", i, lat, bad, exp_lat);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit seen_done;
        @(negedge clk);
        start = 1'b1;
        len = 5'd10;
        xseq = 16'hFFFF;
        yseq = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        tests_run++;
        if ({a_res, a_x, a_y, busy, done, aborted, steps, tr1, tr2, tr3, cnt1, cnt2, cnt3}
            !== {1'b1, 5'b00000, 5'd0, 48'h0, 15'h0}) begin
            tests_fail++;
            $display("FAIL midreset_outputs: got a_res %b busy %b done %b steps %0d tr1 %h cnt1 %0d required 1 0 0 0 0 0",
                     a_res, busy, done, steps, tr1, cnt1);
        end
        seen_done = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done || a_res !== 1'b1 || busy !== 1'b0) begin
            tests_fail++;
            $display("FAIL midreset_idle: got done_seen %b a_res %b busy %b required 0 1 0", seen_done, a_res, busy);
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_abort();
        test_empty();
        test_clamp();
        test_start_busy();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_fail++;
            $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end
endmodule
`default_nettype wire
